dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller.
- Sits between the CPU load/store stage (upstream) and the block-granular data memory (downstream).
- Serves word reads/writes from a line array. On a miss it writes back a dirty victim block, then refills the line from the memory's block read port.

Parameters:
- LINES, 16, number of cache lines; power of two, ≥2.
- WSZ, `WORD_SIZE (32), CPU address/data width.
- BSZ, `BLOCK_SIZE (128), line width in bits; a multiple of WSZ.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  WSZ  byte address; word-aligned (low 2 bits ignored).
- cpu_rd  in  1  read request.
- cpu_wr  in  1  write request.
- cpu_wdata  in  WSZ  store data.
- cpu_rdata  out  WSZ  load data; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_addr  out  WSZ  block-aligned memory address.
- mem_readable  out  1  block read strobe.
- mem_writable  out  1  block write strobe.
- mem_write  out  BSZ  victim block data.
- mem_out1  in  BSZ  block at mem_addr; valid the cycle after the read edge.
- mem_out2  in  BSZ  block at mem_addr+BSZ/8; same timing as mem_out1.

Behaviour:
- Address split, for B = BSZ/8 bytes per line:
  - offset = low log2(B) bits;
  - index = next log2(LINES) bits;
  - tag = remaining upper bits.
- Word k = offset>>2 occupies line bits [BSZ-1-WSZ*k -: WSZ]. Byte 0 of the block is the most significant byte.
- Per-line state: valid, dirty, tag, data.
- Reset:
  - all valid and dirty bits cleared; data and tag contents are don't-care;
  - state = IDLE; cpu_ready, mem_readable, mem_writable = 0; cpu_rdata, mem_addr, mem_write = 0.
  - A reset mid-miss abandons the transaction and loses dirty data. Strobes are low in the cycle after the reset edge.
- Handshake:
  - The CPU holds the request and its inputs stable until it sees cpu_ready=1, then drops the request.
  - IDLE ignores requests during the cycle cpu_ready=1.
  - cpu_rd and cpu_wr both high is treated as a write.
- IDLE:
  - A request is sampled at the edge. Hit = valid && tag match.
  - Read hit: cpu_rdata = the selected word; cpu_ready=1 for the next cycle.
  - Write hit: merge cpu_wdata into the word and set dirty; cpu_ready=1 for the next cycle with cpu_rdata unchanged.
  - Miss: go to WB if the victim is valid && dirty, else go to FILL_REQ.
- WB (1 cycle):
  - mem_writable=1; mem_addr = {victim tag, index, 0}; mem_write = victim data.
  - Clear dirty; go to FILL_REQ.
- FILL_REQ (1 cycle):
  - mem_readable=1; mem_addr = {req tag, index, 0}.
  - Go to FILL_WAIT.
- FILL_WAIT (1 cycle):
  - Install mem_out1 into the line: valid=1, dirty=0, tag = req tag.
  - Go to IDLE. The still-held request then hits.
- Latency, in edges counted from the request-sampling edge:
  - hit: cpu_ready after edge 1;
  - clean miss: after edge 4;
  - dirty miss: after edge 5.
- The strobes are never both high. Each strobe is high for exactly one cycle per transaction.

Optional Feature:
- DCACHE_PREFETCH_EN
- Defined:
  - In FILL_WAIT, mem_out2 is also installed into line n = (index+1) mod LINES, with tag = tag of (mem_addr + B). At index = LINES-1 the index wraps to 0 and the tag increments.
  - The install is skipped if line n is valid && dirty. A clean or invalid line n is overwritten (valid=1, dirty=0).
- Undefined:
  - mem_out2 is ignored. Only the missing line is filled.

Test Plan:
- Reset, then read 0x00000104 with memory block@0x100 = 0x11111111_22222222_33333333_44444444 → readable pulse with mem_addr=0x100; cpu_ready after edge 4; cpu_rdata=0x22222222; no writable pulse.
- Repeat the read of 0x104 → cpu_ready after edge 1; cpu_rdata=0x22222222; no memory strobes.
- Write 0xDEADBEEF to 0x10C (hit), then read 0x00000A00 (same index 0, tag 0xA) → writable pulse with mem_addr=0x100 and mem_write=0x11111111_22222222_33333333_DEADBEEF; then readable with mem_addr=0xA00; cpu_ready after edge 5.
- Assert rst for one cycle while in FILL_WAIT → next cycle cpu_ready=0 and strobes=0; a subsequent read of 0x104 misses.
- cpu_rd=cpu_wr=1 at 0x200 with wdata=5 → handled as a write-allocate; a read of 0x200 then returns 5.
- DCACHE_PREFETCH_EN, read-miss at 0x1F0 (index 15) → line 0 installed with tag of 0x200. A read of 0x200 then hits after edge 1; with the macro undefined the same read misses.

Source files
------------

// File: rtl/dcache_if.sv
// CPU/memory-side signal bundle for the dcache_ctrl data cache controller.
// The cache uses the slave modport; the environment (CPU stage plus memory) uses master.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 128
`endif

interface dcache_if #(
    parameter int WSZ = `WORD_SIZE,
    parameter int BSZ = `BLOCK_SIZE
);
    logic [WSZ-1:0] cpu_addr;
    logic           cpu_rd;
    logic           cpu_wr;
    logic [WSZ-1:0] cpu_wdata;
    logic [WSZ-1:0] cpu_rdata;
    logic           cpu_ready;
    logic [WSZ-1:0] mem_addr;
    logic           mem_readable;
    logic           mem_writable;
    logic [BSZ-1:0] mem_write;
    logic [BSZ-1:0] mem_out1;
    logic [BSZ-1:0] mem_out2;

    modport master (
        output cpu_addr, cpu_rd, cpu_wr, cpu_wdata, mem_out1, mem_out2,
        input  cpu_rdata, cpu_ready, mem_addr, mem_readable, mem_writable, mem_write
    );

    modport slave (
        input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata, mem_out1, mem_out2,
        output cpu_rdata, cpu_ready, mem_addr, mem_readable, mem_writable, mem_write
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Define DCACHE_PREFETCH_EN to also install the next sequential block (mem_out2) on every refill.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 128
`endif

module dcache_ctrl #(
    parameter int LINES = 16,
    parameter int WSZ   = `WORD_SIZE,
    parameter int BSZ   = `BLOCK_SIZE
) (
    input logic     clk,
    input logic     rst,
    dcache_if.slave bus
);
    localparam int B     = BSZ / 8;
    localparam int OFF_W = $clog2(B);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = WSZ - OFF_W - IDX_W;
    localparam int BN_W  = WSZ - OFF_W;
    localparam int BW    = $clog2(BSZ);
    localparam int KW    = OFF_W - 2;

    typedef enum logic [1:0] {IDLE, WB, FILL_REQ, FILL_WAIT} state_e;

    state_e             state_q, state_d;
    logic [LINES-1:0]   valid_q, dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [BSZ-1:0]     data_q [LINES];
    logic               cpu_ready_q;
    logic [WSZ-1:0]     cpu_rdata_q;
    logic [WSZ-1:0]     mem_addr_q;
    logic [BSZ-1:0]     mem_write_q;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   req_tag;
    logic [KW-1:0]      word_k;
    logic [BW-1:0]      wbase;
    logic [WSZ-1:0]     req_blk;
    logic               req, hit, victim_dirty, accept;
    logic               rd_stb, wr_stb;
    logic               unused_addr_bits;

    assign idx          = bus.cpu_addr[OFF_W +: IDX_W];
    assign req_tag      = bus.cpu_addr[WSZ-1 -: TAG_W];
    assign word_k       = bus.cpu_addr[OFF_W-1:2];
    // Word 0 sits in the most significant bits of the line.
    assign wbase        = BW'(BSZ - 1 - WSZ * int'(word_k));
    assign req_blk      = {req_tag, idx, {OFF_W{1'b0}}};
    assign req          = bus.cpu_rd | bus.cpu_wr;
    assign hit          = valid_q[idx] && (tag_q[idx] == req_tag);
    assign victim_dirty = valid_q[idx] && dirty_q[idx];
    assign accept       = (state_q == IDLE) && req && !cpu_ready_q;
    assign unused_addr_bits = ^bus.cpu_addr[1:0];

`ifdef DCACHE_PREFETCH_EN
    logic [BN_W-1:0]  pf_blk;
    logic [IDX_W-1:0] pf_idx;
    logic [TAG_W-1:0] pf_tag;
    logic             pf_ok;

    // Block number increment carries a wrap at the last index into the tag.
    assign pf_blk = mem_addr_q[WSZ-1:OFF_W] + BN_W'(1);
    assign pf_idx = pf_blk[IDX_W-1:0];
    assign pf_tag = pf_blk[BN_W-1 -: TAG_W];
    assign pf_ok  = !(valid_q[pf_idx] && dirty_q[pf_idx]);
`else
    logic unused_out2;
    assign unused_out2 = ^bus.mem_out2;
`endif

    always_comb begin
        state_d = state_q;
        rd_stb  = 1'b0;
        wr_stb  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && !hit) state_d = victim_dirty ? WB : FILL_REQ;
            end
            WB: begin
                wr_stb  = 1'b1;
                state_d = FILL_REQ;
            end
            FILL_REQ: begin
                rd_stb  = 1'b1;
                state_d = FILL_WAIT;
            end
            FILL_WAIT: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_write_q <= '0;
        end else begin
            state_q     <= state_d;
            cpu_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            cpu_ready_q <= 1'b1;
                            if (bus.cpu_wr) dirty_q[idx] <= 1'b1;
                            else            cpu_rdata_q  <= data_q[idx][wbase -: WSZ];
                        end else if (victim_dirty) begin
                            mem_addr_q  <= {tag_q[idx], idx, {OFF_W{1'b0}}};
                            mem_write_q <= data_q[idx];
                        end else begin
                            mem_addr_q  <= req_blk;
                        end
                    end
                end
                WB: begin
                    dirty_q[idx] <= 1'b0;
                    mem_addr_q   <= req_blk;
                end
                FILL_WAIT: begin
                    valid_q[idx] <= 1'b1;
                    dirty_q[idx] <= 1'b0;
`ifdef DCACHE_PREFETCH_EN
                    if (pf_ok) begin
                        valid_q[pf_idx] <= 1'b1;
                        dirty_q[pf_idx] <= 1'b0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // Line storage is not reset; valid bits alone qualify its contents.
    always_ff @(posedge clk) begin
        if (accept && hit && bus.cpu_wr) data_q[idx][wbase -: WSZ] <= bus.cpu_wdata;
        if (state_q == FILL_WAIT) begin
            data_q[idx] <= bus.mem_out1;
            tag_q[idx]  <= req_tag;
`ifdef DCACHE_PREFETCH_EN
            if (pf_ok) begin
                data_q[pf_idx] <= bus.mem_out2;
                tag_q[pf_idx]  <= pf_tag;
            end
`endif
        end
    end

    assign bus.cpu_ready    = cpu_ready_q;
    assign bus.cpu_rdata    = cpu_rdata_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_write    = mem_write_q;
    assign bus.mem_readable = rd_stb;
    assign bus.mem_writable = wr_stb;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: CPU requests push expected data and completion cycle,
// a negedge monitor pops them on cpu_ready; a block memory model serves refills and write-backs.
module tb_dcache_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic mem_init;

    always #5 clk = ~clk;

    dcache_if #(.WSZ(32), .BSZ(128)) bus ();

    dcache_ctrl #(.LINES(16), .WSZ(32), .BSZ(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        int          exp_cyc;
    } exp_t;

    exp_t         exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           rd_cnt = 0;
    int           wr_cnt = 0;
    logic [31:0]  last_rd_addr = '0;
    logic [31:0]  last_wr_addr = '0;
    logic [127:0] last_wr_data = '0;
    logic [127:0] mem_a [256];

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Block 0x100 holds the pattern from the test plan; every other word holds 0xC0000000 | its byte address.
    function automatic logic [127:0] init_val(input int i);
        logic [127:0] v;
        if (i == 16) return 128'h11111111_22222222_33333333_44444444;
        for (int k = 0; k < 4; k++) v[127-32*k -: 32] = 32'hC000_0000 | 32'(i * 16 + 4 * k);
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init_val(i);
        end else begin
            if (bus.mem_writable) begin
                mem_a[bus.mem_addr[11:4]] <= bus.mem_write;
                wr_cnt       <= wr_cnt + 1;
                last_wr_addr <= bus.mem_addr;
                last_wr_data <= bus.mem_write;
            end
            if (bus.mem_readable) begin
                bus.mem_out1 <= mem_a[bus.mem_addr[11:4]];
                bus.mem_out2 <= mem_a[8'(bus.mem_addr[11:4] + 8'd1)];
                rd_cnt       <= rd_cnt + 1;
                last_rd_addr <= bus.mem_addr;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.mem_readable || bus.mem_writable)
            check_eq("strobe_excl", 128'(bus.mem_readable & bus.mem_writable), 128'd0);
        if (!rst && bus.cpu_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_ready", 128'(bus.cpu_ready), 128'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq({e.tag, "_rdata"}, 128'(bus.cpu_rdata), 128'(e.rdata));
                check_eq({e.tag, "_latency_cycle"}, 128'(cyc), 128'(e.exp_cyc));
            end
        end
    end

    task automatic cpu_op(input string tag, input logic [31:0] a, input logic rd, input logic wr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input int lat,
                          input int n_rd, input logic [31:0] rd_addr,
                          input int n_wr, input logic [31:0] wr_addr, input logic [127:0] wr_data);
        int rd0, wr0;
        logic got;
        @(posedge clk);
        #1;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        exp_q.push_back('{tag, exp_rd, cyc + lat});
        bus.cpu_addr  = a;
        bus.cpu_rd    = rd;
        bus.cpu_wr    = wr;
        bus.cpu_wdata = wd;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.cpu_ready;
        end
        bus.cpu_rd = 1'b0;
        bus.cpu_wr = 1'b0;
        if (!got) check_eq({tag, "_timeout"}, 128'(got), 128'd1);
        check_eq({tag, "_n_read_strobes"}, 128'(rd_cnt - rd0), 128'(n_rd));
        if (n_rd > 0) check_eq({tag, "_read_addr"}, 128'(last_rd_addr), 128'(rd_addr));
        check_eq({tag, "_n_write_strobes"}, 128'(wr_cnt - wr0), 128'(n_wr));
        if (n_wr > 0) begin
            check_eq({tag, "_wb_addr"}, 128'(last_wr_addr), 128'(wr_addr));
            check_eq({tag, "_wb_data"}, last_wr_data, wr_data);
        end
    endtask

    initial begin
        int r0;
        rst           = 1'b1;
        mem_init      = 1'b1;
        bus.cpu_addr  = '0;
        bus.cpu_rd    = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);
        check_eq("rst_cpu_ready", 128'(bus.cpu_ready), 128'd0);
        check_eq("rst_readable", 128'(bus.mem_readable), 128'd0);
        check_eq("rst_writable", 128'(bus.mem_writable), 128'd0);
        check_eq("rst_cpu_rdata", 128'(bus.cpu_rdata), 128'd0);
        check_eq("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
        check_eq("rst_mem_write", bus.mem_write, 128'd0);

        cpu_op("rd_miss_104", 32'h104, 1, 0, 0, 32'h22222222, 4, 1, 32'h100, 0, 0, 0);
        cpu_op("rd_hit_104",  32'h104, 1, 0, 0, 32'h22222222, 1, 0, 0, 0, 0, 0);
        cpu_op("wr_hit_10c",  32'h10C, 0, 1, 32'hDEADBEEF, 32'h22222222, 1, 0, 0, 0, 0, 0);
        cpu_op("rd_dirty_a00", 32'hA00, 1, 0, 0, 32'hC0000A00, 5, 1, 32'hA00,
               1, 32'h100, 128'h11111111_22222222_33333333_DEADBEEF);

        // Clean miss at 0x300, reset asserted while the refill is in its wait cycle.
        @(posedge clk);
        #1;
        r0 = rd_cnt;
        bus.cpu_addr = 32'h300;
        bus.cpu_rd   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("midrst_read_issued", 128'(rd_cnt - r0), 128'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        bus.cpu_rd = 1'b0;
        @(negedge clk);
        check_eq("midrst_cpu_ready", 128'(bus.cpu_ready), 128'd0);
        check_eq("midrst_readable", 128'(bus.mem_readable), 128'd0);
        check_eq("midrst_writable", 128'(bus.mem_writable), 128'd0);

        cpu_op("rd_after_rst_104", 32'h104, 1, 0, 0, 32'h22222222, 4, 1, 32'h100, 0, 0, 0);
        cpu_op("rdwr_200", 32'h200, 1, 1, 32'd5, 32'h22222222, 4, 1, 32'h200, 0, 0, 0);
        cpu_op("rd_hit_200", 32'h200, 1, 0, 0, 32'd5, 1, 0, 0, 0, 0, 0);

        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        cpu_op("rd_miss_1f0", 32'h1F0, 1, 0, 0, 32'hC00001F0, 4, 1, 32'h1F0, 0, 0, 0);
`ifdef DCACHE_PREFETCH_EN
        cpu_op("rd_pf_200", 32'h200, 1, 0, 0, 32'hC0000200, 1, 0, 0, 0, 0, 0);
`else
        cpu_op("rd_pf_200", 32'h200, 1, 0, 0, 32'hC0000200, 4, 1, 32'h200, 0, 0, 0);
`endif
        cpu_op("wr_200", 32'h200, 0, 1, 32'd7, 32'hC0000200, 1, 0, 0, 0, 0, 0);
        cpu_op("rd_miss_2f0", 32'h2F0, 1, 0, 0, 32'hC00002F0, 4, 1, 32'h2F0, 0, 0, 0);
        cpu_op("rd_200_kept", 32'h200, 1, 0, 0, 32'd7, 1, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        check_eq("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
